conv_operand_streamer: RTL
==========================

# conv_operand_streamer

Transmitter side of the convolution accelerator's a/b operand handshake. It walks the convolution loop nest in the controller's order, reads feature-map and kernel words from two external single-port memories with 1-cycle read latency, and presents them as paired `a`/`b` beats with valid/ready flow control. Zero padding at feature-map borders is synthesized locally. A 4-entry operand FIFO lets the block sustain one pair per cycle.

## Interface
Parameters:
- `FEATURE_MAP_WIDTH`, default 1024: feature-map columns (W).
- `FEATURE_MAP_HEIGHT`, default 1024: feature-map rows (H).
- `INPUT_NB_CHANNELS`, default 64: input channels (CIN).
- `OUTPUT_NB_CHANNELS`, default 64: output channels (COUT).
- `KERNEL_SIZE`, default 3: kernel side (K, odd); padding PAD = K/2.
- `DATA_WIDTH`, default 16: operand width.
- `ADDR_WIDTH`, default 32: memory address width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `arst_n_in`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle start request; sampled only in IDLE.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse after the last pair is accepted.
- `fm_re`  out  1  feature-map read enable.
- `fm_addr`  out  ADDR_WIDTH  feature-map word address.
- `fm_rdata`  in  DATA_WIDTH  feature-map data, valid 1 cycle after `fm_re`.
- `k_re`  out  1  kernel read enable.
- `k_addr`  out  ADDR_WIDTH  kernel word address.
- `k_rdata`  in  DATA_WIDTH  kernel data, valid 1 cycle after `k_re`.
- `a_valid`, `b_valid`  out  1  operand valid; always equal.
- `a_ready`, `b_ready`  in  1  consumer ready.
- `a_data`  out  DATA_WIDTH  feature operand.
- `b_data`  out  DATA_WIDTH  kernel operand.

## Operation
- Loop nest, outermost first: x (0..W-1), y (0..H-1), ch_in, ch_out, kv, kh. Total pairs N = W·H·CIN·COUT·K·K.
- Per iteration, the feature-map source position is xx = x+kh-PAD and yy = y+kv-PAD.
- a = fm[(yy·W+xx)·CIN+ch_in].
- b = kern[((ch_out·CIN+ch_in)·K+kv)·K+kh].
- Address arithmetic is done in 32-bit signed; the result is truncated to ADDR_WIDTH.
- Padding: if xx or yy is outside the map, `fm_re` stays low for that slot. The slot carries a pad flag through the read pipeline, and a_data=0 is pushed. `k_re` is asserted every slot.
- States:
  - IDLE: on `start`, clear counters and go to RUN.
  - RUN: issue one slot per cycle while credit allows. After issuing slot N-1, go to DRAIN.
  - DRAIN: no issue. Once the FIFO is empty and nothing is pending, pulse `done` and go to IDLE.
- Credit: issue only when occupancy + pending < 4. Pending counts reads whose data is not yet written into the FIFO.
- Write: each read slot is written into the FIFO exactly 1 cycle after issue.
- Transfer occurs when a_valid && a_ready && b_ready. The FIFO head then pops and counters are unaffected, because the issue counters are separate.
- Once valid is raised, data stays stable until the transfer. Valid never drops without a transfer.
- `start` in RUN or DRAIN is ignored.
- Reset values: all outputs 0; state IDLE; FIFO empty; counters 0.
- Reset asserted mid-run aborts immediately. There is no `done` pulse, and outstanding read data is discarded.

## Timing
- Start latency: `start` high in cycle 0 → RUN in cycle 1 with first `fm_re`/`k_re` → rdata in cycle 2, written to the FIFO at the end of cycle 2 → `a_valid` in cycle 3.
- Throughput: with ready held high, one pair per cycle from cycle 3 through cycle N+2.
- `done`: pulses in the cycle after the final transfer.
- Backpressure: with ready low, at most 4 slots are outstanding (FIFO plus pending), then issue stalls. When ready returns, pairs resume the next cycle with no bubble.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Read enables are high only in cycles where a slot is issued. Addresses are don't-care otherwise but are held at their last value.

## Configuration
- `CONV_STREAMER_STALL_CNT_EN` defined:
  - Adds output `stall_cycles` [31:0].
  - It counts cycles with a_valid=1 and (a_ready=0 or b_ready=0).
  - Cleared on accepted `start`; saturates at 2^32-1; reset value 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- Bench configuration: W=H=2, CIN=COUT=1, K=3, memories preloaded with fm[i]=i+1 and kern[i]=i+10.
- Full-throughput run: ready held high → 36 pairs on consecutive cycles 3..38, `done` in cycle 39.
  - First pair is (0,10); it is padded.
  - Pair 4, at (x0,y0,kv1,kh1), is (1,14).
- Padding count: over the full run → exactly 20 pairs have a=0, and `fm_re` pulses exactly 16 times.
- Backpressure: ready low for 10 cycles after the first transfer → valid and data held constant. After 4 slots are outstanding, no further `fm_re`/`k_re`. The full sequence order is unchanged versus the ready-always run.
- Random ready (50%) with CIN=2, COUT=2, K=1 → 16 pairs match the golden model in order, followed by a single `done`.
- Reset at cycle 7: `arst_n_in` low → all outputs 0 next edge; `start` after release → a fresh 36-pair sequence, starting again from (0,10).
- Stall counter, with `CONV_STREAMER_STALL_CNT_EN`: ready low for 5 cycles while valid=1 → `stall_cycles` = 5; a new `start` clears it to 0.

Source files
------------

// File: rtl/conv_operand_streamer.sv
// conv_operand_streamer: walks the convolution loop nest, reads feature-map and kernel words and streams paired a/b operands
// Ports: clk/arst_n_in (async active-low reset), start (accepted in IDLE), busy/done status,
//   fm_re/fm_addr/fm_rdata and k_re/k_addr/k_rdata drive two 1-cycle-latency memories,
//   a_*/b_* form the paired operand stream (a_valid == b_valid).
// Optional: CONV_STREAMER_STALL_CNT_EN adds stall_cycles, a saturating count of cycles with valid held but not accepted.
module conv_operand_streamer #(
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int KERNEL_SIZE        = 3,
  parameter int DATA_WIDTH         = 16,
  parameter int ADDR_WIDTH         = 32
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fm_re,
  output logic [ADDR_WIDTH-1:0] fm_addr,
  input  logic [DATA_WIDTH-1:0] fm_rdata,
  output logic                  k_re,
  output logic [ADDR_WIDTH-1:0] k_addr,
  input  logic [DATA_WIDTH-1:0] k_rdata,
`ifdef CONV_STREAMER_STALL_CNT_EN
  output logic [31:0]           stall_cycles,
`endif
  output logic                  a_valid,
  output logic                  b_valid,
  input  logic                  a_ready,
  input  logic                  b_ready,
  output logic [DATA_WIDTH-1:0] a_data,
  output logic [DATA_WIDTH-1:0] b_data
);
  localparam int PAD = KERNEL_SIZE / 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic signed [31:0] x_q, y_q, ci_q, co_q, kv_q, kh_q;
  logic signed [31:0] x_d, y_d, ci_d, co_d, kv_d, kh_d;
  logic signed [31:0] c_x, c_y, c_ci, c_co, c_kv, c_kh, xx, yy, fa, ka;
  logic w_kh, w_kv, w_co, w_ci, w_y, last, idle_start, pop;
  logic issue_q, issue_d, pad_q, pad_d, wr_q, wr_d, wpad_q, wpad_d;
  logic busy_q, busy_d, done_q, done_d, fm_re_q, fm_re_d, k_re_q, k_re_d;
  logic [ADDR_WIDTH-1:0] fm_addr_q, fm_addr_d, k_addr_q, k_addr_d;
  logic [2:0] occ_q, occ_d;
  logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] a_mem_q [4], a_mem_d [4], b_mem_q [4], b_mem_d [4];
`ifdef CONV_STREAMER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  assign stall_cycles = stall_q;
`endif
  assign busy    = busy_q;
  assign done    = done_q;
  assign fm_re   = fm_re_q;
  assign k_re    = k_re_q;
  assign fm_addr = fm_addr_q;
  assign k_addr  = k_addr_q;
  assign a_valid = occ_q != 3'd0;
  assign b_valid = occ_q != 3'd0;
  assign a_data  = a_mem_q[rptr_q];
  assign b_data  = b_mem_q[rptr_q];
  always_comb begin
    pop = a_valid && a_ready && b_ready;
    wr_d = issue_q;
    wpad_d = pad_q;
    occ_d = occ_q + {2'b00, wr_q} - {2'b00, pop};
    wptr_d = wptr_q + {1'b0, wr_q};
    rptr_d = rptr_q + {1'b0, pop};
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    if (wr_q) begin
      a_mem_d[wptr_q] = wpad_q ? '0 : fm_rdata;
      b_mem_d[wptr_q] = k_rdata;
    end
    idle_start = state_q == IDLE && start;
    c_x  = idle_start ? '0 : x_q;
    c_y  = idle_start ? '0 : y_q;
    c_ci = idle_start ? '0 : ci_q;
    c_co = idle_start ? '0 : co_q;
    c_kv = idle_start ? '0 : kv_q;
    c_kh = idle_start ? '0 : kh_q;
    // next cycle's outstanding slots = FIFO after this edge + read in flight + new issue
    issue_d = idle_start || (state_q == RUN && {1'b0, occ_d} + {3'b000, issue_q} < 4'd4);
    xx = c_x + c_kh - PAD;
    yy = c_y + c_kv - PAD;
    pad_d = xx < 0 || xx >= FEATURE_MAP_WIDTH || yy < 0 || yy >= FEATURE_MAP_HEIGHT;
    fa = (yy * FEATURE_MAP_WIDTH + xx) * INPUT_NB_CHANNELS + c_ci;
    ka = ((c_co * INPUT_NB_CHANNELS + c_ci) * KERNEL_SIZE + c_kv) * KERNEL_SIZE + c_kh;
    w_kh = c_kh == KERNEL_SIZE - 1;
    w_kv = w_kh && c_kv == KERNEL_SIZE - 1;
    w_co = w_kv && c_co == OUTPUT_NB_CHANNELS - 1;
    w_ci = w_co && c_ci == INPUT_NB_CHANNELS - 1;
    w_y  = w_ci && c_y == FEATURE_MAP_HEIGHT - 1;
    last = w_y && c_x == FEATURE_MAP_WIDTH - 1;
    kh_d = !issue_d ? c_kh : w_kh ? '0 : c_kh + 1;
    kv_d = !(issue_d && w_kh) ? c_kv : w_kv ? '0 : c_kv + 1;
    co_d = !(issue_d && w_kv) ? c_co : w_co ? '0 : c_co + 1;
    ci_d = !(issue_d && w_co) ? c_ci : w_ci ? '0 : c_ci + 1;
    y_d  = !(issue_d && w_ci) ? c_y : w_y ? '0 : c_y + 1;
    x_d  = !(issue_d && w_y) ? c_x : last ? '0 : c_x + 1;
    fm_re_d = issue_d && !pad_d;
    k_re_d = issue_d;
    fm_addr_d = fm_re_d ? fa[ADDR_WIDTH-1:0] : fm_addr_q;
    k_addr_d = issue_d ? ka[ADDR_WIDTH-1:0] : k_addr_q;
    done_d = state_q == DRAIN && occ_d == 3'd0 && !issue_q;
    state_d = issue_d && last ? DRAIN : idle_start ? RUN : done_d ? IDLE : state_q;
    busy_d = state_d != IDLE;
`ifdef CONV_STREAMER_STALL_CNT_EN
    stall_d = idle_start ? '0 : a_valid && !(a_ready && b_ready) && stall_q != '1 ? stall_q + 1 : stall_q;
`endif
  end
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q <= IDLE;
      {x_q, y_q, ci_q, co_q, kv_q, kh_q} <= '0;
      {issue_q, pad_q, wr_q, wpad_q, busy_q, done_q, fm_re_q, k_re_q} <= '0;
      fm_addr_q <= '0;
      k_addr_q <= '0;
      occ_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      a_mem_q <= '{default: '0};
      b_mem_q <= '{default: '0};
`ifdef CONV_STREAMER_STALL_CNT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      {x_q, y_q, ci_q, co_q, kv_q, kh_q} <= {x_d, y_d, ci_d, co_d, kv_d, kh_d};
      {issue_q, pad_q, wr_q, wpad_q, busy_q, done_q, fm_re_q, k_re_q} <=
        {issue_d, pad_d, wr_d, wpad_d, busy_d, done_d, fm_re_d, k_re_d};
      fm_addr_q <= fm_addr_d;
      k_addr_q <= k_addr_d;
      occ_q <= occ_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      a_mem_q <= a_mem_d;
      b_mem_q <= b_mem_d;
`ifdef CONV_STREAMER_STALL_CNT_EN
      stall_q <= stall_d;
`endif
    end
  end
endmodule
